// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter merging NUM_SRC AXI-stream requesters into one registered stream.
// Define AXIS_ARB_BURST_EN to let a grant carry up to BURST_LEN beats; otherwise one beat per grant.
module axis_rr_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int bus_width = 256,
  parameter int BURST_LEN = 8
) (
  input  logic                         axis_clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           s_axis_tvalid,
  output logic [NUM_SRC-1:0]           s_axis_tready,
  input  logic [NUM_SRC*bus_width-1:0] s_axis_tdata,
  output logic [bus_width-1:0]         m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [$clog2(NUM_SRC)-1:0]   m_axis_tsrc
);

  localparam int SRC_W = $clog2(NUM_SRC);

`ifdef AXIS_ARB_BURST_EN
  localparam logic [7:0] BEAT_LIMIT = 8'(BURST_LEN);
`else
  localparam logic [7:0] BEAT_LIMIT = 8'd1;
`endif

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state_r;
  logic [SRC_W-1:0]     grant_r;
  logic [SRC_W-1:0]     last_grant_r;
  logic [7:0]           beat_cnt_r;

  logic [SRC_W-1:0]     pick_s;
  logic                 pick_vld_s;
  logic [SRC_W-1:0]     idx_s;
  logic                 xfer_s;
  logic [7:0]           beat_nxt_s;
  logic                 grant_end_s;
  logic [bus_width-1:0] sel_data_s;

  // Rotating priority search: descending loop so the nearest index after last_grant wins.
  always_comb begin
    pick_s     = {SRC_W{1'b0}};
    idx_s      = {SRC_W{1'b0}};
    pick_vld_s = |s_axis_tvalid;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx_s  = SRC_W'((int'(last_grant_r) + k) % NUM_SRC);
      pick_s = s_axis_tvalid[idx_s] ? idx_s : pick_s;
    end
  end

  // Ready is only offered to the granted requester, and only when the output slot can take a beat.
  always_comb begin
    s_axis_tready = {NUM_SRC{1'b0}};
    if (state_r == GRANT) begin
      s_axis_tready[grant_r] = !m_axis_tvalid || m_axis_tready;
    end else begin
      s_axis_tready = {NUM_SRC{1'b0}};
    end
  end

  // Data mux for the granted requester.
  always_comb begin
    sel_data_s = {bus_width{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_data_s = (grant_r == SRC_W'(i)) ? s_axis_tdata[i*bus_width +: bus_width] : sel_data_s;
    end
  end

  // Beat counter saturates so it can never wrap inside a grant.
  always_comb begin
    xfer_s      = s_axis_tvalid[grant_r] && s_axis_tready[grant_r];
    beat_nxt_s  = (beat_cnt_r == 8'hFF) ? 8'hFF : (beat_cnt_r + 8'd1);
    grant_end_s = !s_axis_tvalid[grant_r] || (xfer_s && (beat_nxt_s == BEAT_LIMIT));
  end

  // Arbitration FSM: IDLE picks the next requester, GRANT streams until release or beat limit.
  always_ff @(posedge axis_clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= {SRC_W{1'b0}};
      last_grant_r <= SRC_W'(NUM_SRC - 1);
      beat_cnt_r   <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_vld_s) begin
            grant_r    <= pick_s;
            beat_cnt_r <= 8'd0;
            state_r    <= GRANT;
          end
        end
        GRANT: begin
          if (xfer_s) begin
            beat_cnt_r <= beat_nxt_s;
          end
          if (grant_end_s) begin
            last_grant_r <= grant_r;
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Output register: load on transfer, drop valid on unload with no new beat, hold otherwise.
  always_ff @(posedge axis_clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= {bus_width{1'b0}};
      m_axis_tsrc   <= {SRC_W{1'b0}};
    end else if (xfer_s) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= sel_data_s;
      m_axis_tsrc   <= grant_r;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: directed source programs push expected beats,
// a negedge monitor pops and compares every accepted output beat plus stall/hold rules.
module tb_axis_rr_arbiter;

  localparam int NS = 4;
  localparam int BW = 256;
  localparam int BL = 8;

`ifdef AXIS_ARB_BURST_EN
  localparam int CHUNK   = BL;
  localparam int REL_GAP = 3;
`else
  localparam int CHUNK   = 1;
  localparam int REL_GAP = 2;
`endif

  typedef struct {
    int             src;
    logic [BW-1:0]  data;
    int             gap;
  } exp_t;

  exp_t exp_q[$];

  logic              axis_clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     s_axis_tvalid;
  logic [NS-1:0]     s_axis_tready;
  logic [NS*BW-1:0]  s_axis_tdata;
  logic [BW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [1:0]        m_axis_tsrc;

  int            vec_cnt = 0;
  int            err_cnt = 0;
  int            src_cnt[NS];
  int            src_left[NS];
  int            exp_cnt[NS];
  logic [NS-1:0] acc_s = '0;
  int            mcyc = 0;
  int            last_beat = 0;
  bit            stall_prev = 1'b0;
  logic [BW-1:0] prev_data = '0;
  logic [1:0]    prev_src = '0;
  int            tcyc = 0;
  bit            bp_en = 1'b0;
  logic          mr_level = 1'b1;

  axis_rr_arbiter #(.NUM_SRC(NS), .bus_width(BW), .BURST_LEN(BL)) dut (
    .axis_clk      (axis_clk),
    .rst           (rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tsrc   (m_axis_tsrc)
  );

  always #5 axis_clk = ~axis_clk;

  function automatic logic [BW-1:0] tag(input int s, input int n);
    logic [BW-1:0] t;
    for (int k = 0; k < BW/32; k++) t[k*32 +: 32] = {8'(k), 8'(s), 16'(n)};
    return t;
  endfunction

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    vec_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      s_axis_tvalid[i]         = (src_left[i] > 0);
      s_axis_tdata[i*BW +: BW] = tag(i, src_cnt[i]);
    end
    m_axis_tready = bp_en ? ((tcyc % 13) >= 5) : mr_level;
  endtask

  task automatic tick();
    @(posedge axis_clk);
    #1;
    tcyc++;
    for (int i = 0; i < NS; i++) begin
      if (acc_s[i]) begin
        src_cnt[i]++;
        src_left[i]--;
      end
    end
    drive();
  endtask

  task automatic push(input int s, input int n, input int gap_first, input int gap_rest);
    for (int j = 0; j < n; j++) begin
      exp_q.push_back('{s, tag(s, exp_cnt[s]), (j == 0) ? gap_first : gap_rest});
      exp_cnt[s]++;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    int left = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL drain_%s: actual %0d beats pending after %0d cycles, required 0", name, exp_q.size(), budget);
    end
    for (int i = 0; i < NS; i++) left += src_left[i];
    check({"sources_done_", name}, BW'(left), BW'(0));
    repeat (3) tick();
  endtask

  // Scoreboard monitor: sample away from the active edge, pop on every accepted output beat.
  always @(negedge axis_clk) begin
    exp_t e;
    mcyc++;
    acc_s = s_axis_tvalid & s_axis_tready;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", BW'(m_axis_tvalid), BW'(1));
        check("hold_data", m_axis_tdata, prev_data);
        check("hold_src", BW'(m_axis_tsrc), BW'(prev_src));
      end
      if (m_axis_tvalid && !m_axis_tready) check("stall_s_tready", BW'(s_axis_tready), BW'(0));
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL unexpected_beat: actual src %0d data %0h, required no beat", m_axis_tsrc, m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          check("beat_src", BW'(m_axis_tsrc), BW'(e.src));
          check("beat_data", m_axis_tdata, e.data);
          if (e.gap != 0) check("beat_gap", BW'(mcyc - last_beat), BW'(e.gap));
        end
        last_beat = mcyc;
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_src   = m_axis_tsrc;
    end
  end

  initial begin
    int n;
    int la;
    int lb;
    int na;
    int rounds;
    rst = 1'b1;
    for (int i = 0; i < NS; i++) begin
      src_cnt[i] = 0;
      exp_cnt[i] = 0;
    end
    // Reset with all requesters valid; program the round-robin test sources now.
    rounds = (CHUNK == 1) ? 2 : 1;
    for (int i = 0; i < NS; i++) src_left[i] = rounds * CHUNK;
    mr_level = 1'b1;
    drive();
    for (int c = 0; c < 4; c++) begin
      tick();
      check("rst_m_tvalid", BW'(m_axis_tvalid), BW'(0));
      check("rst_s_tready", BW'(s_axis_tready), BW'(0));
      check("rst_m_tdata", m_axis_tdata, BW'(0));
      check("rst_m_tsrc", BW'(m_axis_tsrc), BW'(0));
    end

    // Round robin across all four requesters, first grant to requester 0.
    for (int r = 0; r < rounds; r++)
      for (int i = 0; i < NS; i++) push(i, CHUNK, (r == 0 && i == 0) ? 0 : 2, 1);
    rst = 1'b0;
    drain("round_robin", 400);

    // Requesters 1 and 2 alternate.
    src_left[1] = 2 * CHUNK;
    src_left[2] = 2 * CHUNK;
    drive();
    for (int r = 0; r < 2; r++) begin
      push(1, CHUNK, (r == 0) ? 0 : 2, 1);
      push(2, CHUNK, 2, 1);
    end
    drain("pair", 400);

    // Backpressure over 100 tagged beats from requesters 0 and 2.
    src_left[0] = 50;
    src_left[2] = 50;
    la = 50;
    lb = 50;
    while (la > 0 || lb > 0) begin
      na = (la < CHUNK) ? la : CHUNK;
      push(0, na, 0, 0);
      la -= na;
      na = (lb < CHUNK) ? lb : CHUNK;
      push(2, na, 0, 0);
      lb -= na;
    end
    bp_en = 1'b1;
    drive();
    drain("backpressure", 3000);
    bp_en = 1'b0;
    drive();

    // Early release: requester 3 offers only two beats, requester 0 waits.
    src_left[3] = 2;
    src_left[0] = 3;
    drive();
`ifdef AXIS_ARB_BURST_EN
    push(3, 2, 0, 1);
    push(0, 3, REL_GAP, 1);
`else
    push(3, 1, 0, 0);
    push(0, 1, 2, 0);
    push(3, 1, 2, 0);
    push(0, 2, 2, 2);
`endif
    drain("early_release", 200);

    // Mid-transfer reset: stall a beat from requester 1, then reset underneath it.
    mr_level    = 1'b0;
    src_left[1] = 5;
    drive();
    n = 0;
    while (!m_axis_tvalid && n < 20) begin
      tick();
      n++;
    end
    check("midrst_beat_loaded", BW'(m_axis_tvalid), BW'(1));
    rst = 1'b1;
    #1;
    check("midrst_m_tvalid", BW'(m_axis_tvalid), BW'(0));
    check("midrst_m_tdata", m_axis_tdata, BW'(0));
    check("midrst_s_tready", BW'(s_axis_tready), BW'(0));
    exp_cnt[1]++;
    src_left[0] = 1;
    src_left[1] = 1;
    mr_level    = 1'b1;
    drive();
    tick();
    tick();
    push(0, 1, 0, 0);
    push(1, 1, REL_GAP, 0);
    rst = 1'b0;
    drain("mid_reset", 200);

    check("queue_empty", BW'(exp_q.size()), BW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
